// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// adc_spi_responder : device-side model of the 8-channel serial ADC, driven
// by the controller's SCLK/CS_N/SADDR and oversampled by CLOCK.
// Optional build macro: ADC_RESP_RAMP_EN (samples become {addr, frame count}).
// Revision: 1.0
// ============================================================================
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ADC_SCLK,
  input  logic        ADC_CS_N,
  input  logic        ADC_SADDR,
  output logic        ADC_SDAT,
  input  logic [11:0] CH0,
  input  logic [11:0] CH1,
  input  logic [11:0] CH2,
  input  logic [11:0] CH3,
  input  logic [11:0] CH4,
  input  logic [11:0] CH5,
  input  logic [11:0] CH6,
  input  logic [11:0] CH7,
  output logic        FRAME_DONE,
  output logic        FRAME_ERR,
  output logic [2:0]  LAST_ADDR
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_saddr_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic                   r_saddr_d;
  logic                   r_sclk_rise;
  logic                   r_sclk_fall;
  logic                   r_cs_fall;
  logic                   r_cs_rise;

  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic [11:0]            w_sample;

  state_t                 r_state;
  logic [15:0]            r_shift;
  logic [4:0]             r_cnt;
  logic [2:0]             r_addr;
  logic [2:0]             r_pend;
  logic                   r_done;
  logic                   r_err;
  logic [2:0]             r_last;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

  // Synchronizers reset to the idle line levels so release never fakes an edge.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_sclk_sync  <= '1;
      r_cs_sync    <= '1;
      r_saddr_sync <= '0;
      r_sclk_d     <= 1'b1;
      r_cs_d       <= 1'b1;
      r_saddr_d    <= 1'b0;
      r_sclk_rise  <= 1'b0;
      r_sclk_fall  <= 1'b0;
      r_cs_fall    <= 1'b0;
      r_cs_rise    <= 1'b0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
      r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], ADC_CS_N};
      r_saddr_sync <= {r_saddr_sync[SYNC_STAGES-2:0], ADC_SADDR};
      r_sclk_d     <= w_sclk_s;
      r_cs_d       <= w_cs_s;
      r_saddr_d    <= r_saddr_sync[SYNC_STAGES-1];
      r_sclk_rise  <= w_sclk_s & ~r_sclk_d;
      r_sclk_fall  <= ~w_sclk_s & r_sclk_d;
      r_cs_fall    <= ~w_cs_s & r_cs_d;
      r_cs_rise    <= w_cs_s & ~r_cs_d;
    end
  end

`ifdef ADC_RESP_RAMP_EN
  logic [8:0] r_frame_cnt;
  logic       w_unused_ch;

  assign w_sample    = {r_pend, r_frame_cnt};
  assign w_unused_ch = ^{CH0, CH1, CH2, CH3, CH4, CH5, CH6, CH7};
`else
  always_comb begin
    w_sample = CH0;
    case (r_pend)
      3'd0:    w_sample = CH0;
      3'd1:    w_sample = CH1;
      3'd2:    w_sample = CH2;
      3'd3:    w_sample = CH3;
      3'd4:    w_sample = CH4;
      3'd5:    w_sample = CH5;
      3'd6:    w_sample = CH6;
      default: w_sample = CH7;
    endcase
  end
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_shift     <= 16'h0000;
      r_cnt       <= 5'd0;
      r_addr      <= 3'd0;
      r_pend      <= 3'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_last      <= 3'd0;
`ifdef ADC_RESP_RAMP_EN
      r_frame_cnt <= 9'd0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A CS_N pulse narrower than one sample is treated as no frame.
          if (r_cs_fall && !r_cs_rise) begin
            r_state <= ST_ACTIVE;
            r_shift <= {4'b0000, w_sample};
            r_cnt   <= 5'd0;
          end
        end
        ST_ACTIVE: begin
          if (r_cs_rise) begin
            r_state <= ST_IDLE;
            r_shift <= 16'h0000;
            if (r_cnt == 5'd16) begin
              r_done <= 1'b1;
              r_pend <= r_addr;
              r_last <= r_addr;
`ifdef ADC_RESP_RAMP_EN
              r_frame_cnt <= r_frame_cnt + 9'd1;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            if (r_sclk_rise) begin
              if (r_cnt != 5'd31) begin
                r_cnt <= r_cnt + 5'd1;
              end
              case (r_cnt)
                5'd2:    r_addr[2] <= r_saddr_d;
                5'd3:    r_addr[1] <= r_saddr_d;
                5'd4:    r_addr[0] <= r_saddr_d;
                default: ;
              endcase
            end
            // Zeros shift in behind the sample, so DOUT reads 0 after bit 0.
            if (r_sclk_fall && (r_cnt != 5'd0)) begin
              r_shift <= {r_shift[14:0], 1'b0};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ADC_SDAT   = r_shift[15];
  assign FRAME_DONE = r_done;
  assign FRAME_ERR  = r_err;
  assign LAST_ADDR  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
// Bench for adc_spi_responder: table of frames plus reset and ramp sequences.
module tb_adc_spi_responder;

  localparam int H = 40;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        ADC_SCLK;
  logic        ADC_CS_N;
  logic        ADC_SADDR;
  logic        ADC_SDAT;
  logic [11:0] CH0, CH1, CH2, CH3, CH4, CH5, CH6, CH7;
  logic        FRAME_DONE;
  logic        FRAME_ERR;
  logic [2:0]  LAST_ADDR;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;

  adc_spi_responder #(.SYNC_STAGES(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .ADC_SCLK(ADC_SCLK), .ADC_CS_N(ADC_CS_N), .ADC_SADDR(ADC_SADDR),
    .ADC_SDAT(ADC_SDAT),
    .CH0(CH0), .CH1(CH1), .CH2(CH2), .CH3(CH3),
    .CH4(CH4), .CH5(CH5), .CH6(CH6), .CH7(CH7),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR), .LAST_ADDR(LAST_ADDR)
  );

  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (FRAME_DONE) n_done++;
    if (FRAME_ERR)  n_err++;
  end

  typedef struct {
    logic [2:0]  addr;
    int          nrise;
    bit          chg;
    logic [15:0] word;
    int          done;
    int          err;
    logic [2:0]  last;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drives one frame; d collects ADC_SDAT sampled just before each SCLK rise.
  task automatic frame(input logic [2:0] addr, input int nrise, input bit chg,
                       output logic [31:0] d, output int dd, output int de);
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    d  = 32'h0;
    ADC_CS_N = 1'b0;
    #(H);
    for (int i = 1; i <= nrise; i++) begin
      ADC_SCLK = 1'b0;
      if (i == 3)      ADC_SADDR = addr[2];
      else if (i == 4) ADC_SADDR = addr[1];
      else if (i == 5) ADC_SADDR = addr[0];
      else             ADC_SADDR = 1'b0;
      if (chg && i == 8) CH1 = 12'hFFF;
      #(H-1);
      d = {d[30:0], ADC_SDAT};
      #1;
      ADC_SCLK = 1'b1;
      #(H);
    end
    ADC_CS_N  = 1'b1;
    ADC_SADDR = 1'b0;
    #100;
    dd = n_done - d0;
    de = n_err - e0;
  endtask

  logic [31:0] d, exp_d;
  int          dd, de;
  int          bad_done;

  initial begin
    RESET = 1'b1; ADC_SCLK = 1'b1; ADC_CS_N = 1'b1; ADC_SADDR = 1'b0;
    CH0 = 12'hABC; CH1 = 12'h5A5; CH2 = 12'h2D2; CH3 = 12'h3C3;
    CH4 = 12'h444; CH5 = 12'h123; CH6 = 12'h6E6; CH7 = 12'h7F1;

    vt[0] = '{3'd5, 16, 1'b0, 16'h0ABC, 1, 0, 3'd5};
    vt[1] = '{3'd3, 16, 1'b0, 16'h0123, 1, 0, 3'd3};
    vt[2] = '{3'd7, 16, 1'b0, 16'h03C3, 1, 0, 3'd7};
    vt[3] = '{3'd0, 16, 1'b0, 16'h07F1, 1, 0, 3'd0};
    vt[4] = '{3'd6, 10, 1'b0, 16'h0ABC, 0, 1, 3'd0};
    vt[5] = '{3'd2, 16, 1'b0, 16'h0ABC, 1, 0, 3'd2};
    vt[6] = '{3'd1, 16, 1'b0, 16'h02D2, 1, 0, 3'd1};
    vt[7] = '{3'd4, 17, 1'b1, 16'h05A5, 0, 1, 3'd1};
    vt[8] = '{3'd3, 16, 1'b0, 16'h05A5, 1, 0, 3'd3};

    #42;
    check("rst_sdat", {31'h0, ADC_SDAT}, 32'h0);
    check("rst_done", {31'h0, FRAME_DONE}, 32'h0);
    check("rst_err",  {31'h0, FRAME_ERR}, 32'h0);
    check("rst_last", {29'h0, LAST_ADDR}, 32'h0);
    RESET = 1'b0;
    #(H);
    check("idle_sdat", {31'h0, ADC_SDAT}, 32'h0);

`ifndef ADC_RESP_RAMP_EN
    for (int k = 0; k < 9; k++) begin
      frame(vt[k].addr, vt[k].nrise, vt[k].chg, d, dd, de);
      CH1 = 12'h5A5;
      if (vt[k].nrise <= 16) exp_d = {16'h0, vt[k].word} >> (16 - vt[k].nrise);
      else                   exp_d = {16'h0, vt[k].word} << (vt[k].nrise - 16);
      check($sformatf("v%0d_data", k), d, exp_d);
      check($sformatf("v%0d_done", k), dd, vt[k].done);
      check($sformatf("v%0d_err", k), de, vt[k].err);
      check($sformatf("v%0d_last", k), {29'h0, LAST_ADDR}, {29'h0, vt[k].last});
      check($sformatf("v%0d_sdat_idle", k), {31'h0, ADC_SDAT}, 32'h0);
    end

    // Reset mid-frame while channel 3 is streaming out; bit 7 of 0x3C3 is 1.
    ADC_CS_N = 1'b0;
    #(H);
    for (int i = 1; i <= 8; i++) begin
      ADC_SCLK = 1'b0; #(H);
      ADC_SCLK = 1'b1; #(H);
    end
    ADC_SCLK = 1'b0;
    #(H);
    check("pre_rst_bit7", {31'h0, ADC_SDAT}, 32'h1);
    RESET = 1'b1;
    #1;
    check("midrst_sdat", {31'h0, ADC_SDAT}, 32'h0);
    check("midrst_last", {29'h0, LAST_ADDR}, 32'h0);
    ADC_CS_N = 1'b1; ADC_SCLK = 1'b1;
    #99;
    RESET = 1'b0;
    #(H);
    frame(3'd0, 16, 1'b0, d, dd, de);
    check("post_rst_data", d, 32'h0000_0ABC);
    check("post_rst_done", dd, 1);
    check("post_rst_err", de, 0);
    check("post_rst_last", {29'h0, LAST_ADDR}, 32'h0);
`else
    bad_done = 0;
    for (int k = 1; k <= 513; k++) begin
      frame(3'd2, 16, 1'b0, d, dd, de);
      if (dd != 1 || de != 0) bad_done++;
      if (k == 1)   check("ramp_f1",   d, 32'h0000_0000);
      if (k == 2)   check("ramp_f2",   d, 32'h0000_0401);
      if (k == 512) check("ramp_f512", d, 32'h0000_05FF);
      if (k == 513) check("ramp_f513", d, 32'h0000_0400);
    end
    check("ramp_bad_frames", bad_done, 0);
    check("ramp_last", {29'h0, LAST_ADDR}, 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
